// File: rtl/load_store_unit.sv
// Load/store unit: byte/word access to a 16-bit word memory.
// Byte stores read-modify-write through mem_wd as the merge register.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic        is_byte,
   input  logic        sign_ext,
   input  logic [15:0] base,
   input  logic [15:0] offset,
   input  logic [15:0] wdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wd,
   input  logic [15:0] mem_rd,
   output logic [15:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPT,
      WRITE,
      DONE
   } state_t;

   localparam logic [31:0] WORDS = 32'(MEM_WORDS);

   state_t      state;
   logic        st_q;
   logic        byte_q;
   logic        sx_q;
   logic        lane_q;
   logic [7:0]  wb_q;

   logic [15:0] eff;
   logic [14:0] widx;
   logic        oob;
   logic [7:0]  rd_byte;
   logic [15:0] ld_val;
   logic [15:0] merge;

   always_comb begin
      eff   = base + offset;
      widx  = eff[15:1];
      oob   = ({17'd0, widx} >= WORDS);
      rd_byte = lane_q ? mem_rd[15:8] : mem_rd[7:0];
      ld_val  = mem_rd;
      if (byte_q) begin
         ld_val = {{8{sx_q & rd_byte[7]}}, rd_byte};
      end
      merge = lane_q ? {wb_q, mem_rd[7:0]} : {mem_rd[15:8], wb_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         st_q      <= 1'b0;
         byte_q    <= 1'b0;
         sx_q      <= 1'b0;
         lane_q    <= 1'b0;
         wb_q      <= 8'd0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= 16'd0;
         mem_wd    <= 16'd0;
         load_data <= 16'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  st_q     <= is_store;
                  byte_q   <= is_byte;
                  sx_q     <= sign_ext;
                  lane_q   <= eff[0];
                  wb_q     <= wdata[7:0];
                  mem_addr <= {1'b0, widx};
                  busy     <= 1'b1;
                  if (oob) begin
                     fault <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (is_store && !is_byte) begin
                     fault     <= 1'b0;
                     mem_wd    <= wdata;
                     mem_write <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     fault    <= 1'b0;
                     mem_read <= 1'b1;
                     state    <= READ;
                  end
               end
            end
            READ: begin
               state <= CAPT;
            end
            CAPT: begin
               if (st_q) begin
                  mem_wd    <= merge;
                  mem_write <= 1'b1;
                  state     <= WRITE;
               end else begin
                  load_data <= ld_val;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            WRITE: begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               fault <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a memory model and a
// scoreboard of expected completions.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        is_store;
   logic        is_byte;
   logic        sign_ext;
   logic [15:0] base;
   logic [15:0] offset;
   logic [15:0] wdata;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wd;
   logic [15:0] mem_rd;
   logic [15:0] load_data;
   logic        busy;
   logic        done;
   logic        fault;

   typedef struct {
      string       tag;
      int          lat;
      logic        flt;
      logic [15:0] ld;
      int          rds;
      int          wrs;
      logic [15:0] addr;
      logic [15:0] wd;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem[256];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          both_cnt = 0;
   logic [15:0] last_addr = 16'd0;
   logic [15:0] last_wd = 16'd0;

   load_store_unit #(.MEM_WORDS(256)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_store  (is_store),
      .is_byte   (is_byte),
      .sign_ext  (sign_ext),
      .base      (base),
      .offset    (offset),
      .wdata     (wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd),
      .load_data (load_data),
      .busy      (busy),
      .done      (done),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_read) begin
         mem_rd <= mem[mem_addr[7:0]];
         rd_cnt++;
      end
      if (mem_write) begin
         mem[mem_addr[7:0]] <= mem_wd;
         wr_cnt++;
         last_addr = mem_addr;
         last_wd   = mem_wd;
      end
      if (mem_read && mem_write) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op(input string tag, input logic st, input logic byt,
                     input logic sx, input logic [15:0] b,
                     input logic [15:0] o, input logic [15:0] wd,
                     input int lat, input logic flt, input logic [15:0] ld,
                     input int rds, input int wrs,
                     input logic [15:0] addr, input logic [15:0] mwd,
                     input bit poke);
      exp_t e;
      int   r0;
      int   w0;
      int   n;
      logic got;
      e.tag = tag; e.lat = lat; e.flt = flt; e.ld = ld;
      e.rds = rds; e.wrs = wrs; e.addr = addr; e.wd = mwd;
      sb.push_back(e);
      r0 = rd_cnt;
      w0 = wr_cnt;
      @(negedge clk);
      start = 1'b1; is_store = st; is_byte = byt; sign_ext = sx;
      base = b; offset = o; wdata = wd;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 1;
      if (poke) begin
         start = 1'b1; is_store = 1'b1; is_byte = 1'b0;
         base = 16'h0000; offset = 16'h0000; wdata = 16'hDEAD;
      end
      while (!done && n < 12) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
      end
      got = done;
      e = sb.pop_front();
      chk({e.tag, " done"}, 32'(got), 32'd1);
      chk({e.tag, " latency"}, n, e.lat);
      chk({e.tag, " fault"}, 32'(fault), 32'(e.flt));
      chk({e.tag, " load_data"}, 32'(load_data), 32'(e.ld));
      chk({e.tag, " reads"}, rd_cnt - r0, e.rds);
      chk({e.tag, " writes"}, wr_cnt - w0, e.wrs);
      if (e.wrs > 0) begin
         chk({e.tag, " wr addr"}, 32'(last_addr), 32'(e.addr));
         chk({e.tag, " wr data"}, 32'(last_wd), 32'(e.wd));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({e.tag, " idle busy"}, 32'(busy), 32'd0);
      chk({e.tag, " idle done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem_rd = 16'h0000;
      rst_n = 1'b0; start = 1'b0; is_store = 1'b0; is_byte = 1'b0;
      sign_ext = 1'b0; base = 16'h0; offset = 16'h0; wdata = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst fault", 32'(fault), 0);
      chk("rst strobes", 32'({mem_read, mem_write}), 0);
      chk("rst addr", 32'(mem_addr), 0);
      chk("rst wd", 32'(mem_wd), 0);
      chk("rst ld", 32'(load_data), 0);
      rst_n = 1'b1;

      op("wst", 1, 0, 0, 16'h0010, 16'h0004, 16'hBEEF,
         2, 0, 16'h0000, 0, 1, 16'h000A, 16'hBEEF, 0);
      op("wld", 0, 0, 0, 16'h0010, 16'h0004, 16'h0000,
         3, 0, 16'hBEEF, 1, 0, 16'h0, 16'h0, 1);
      op("bld sx", 0, 1, 1, 16'h0015, 16'h0000, 16'h0000,
         3, 0, 16'hFFBE, 1, 0, 16'h0, 16'h0, 0);
      op("bld zx", 0, 1, 0, 16'h0010, 16'h0005, 16'h0000,
         3, 0, 16'h00BE, 1, 0, 16'h0, 16'h0, 0);
      op("bst", 1, 1, 0, 16'h0014, 16'h0000, 16'h0012,
         4, 0, 16'h00BE, 1, 1, 16'h000A, 16'hBE12, 0);
      op("wld2", 0, 0, 0, 16'h0014, 16'h0000, 16'h0000,
         3, 0, 16'hBE12, 1, 0, 16'h0, 16'h0, 0);
      op("fault", 0, 0, 0, 16'h0100, 16'h0100, 16'h0000,
         1, 1, 16'hBE12, 0, 0, 16'h0, 16'h0, 1);
      op("fault st", 1, 1, 0, 16'hFFF0, 16'h0000, 16'h0077,
         1, 1, 16'hBE12, 0, 0, 16'h0, 16'h0, 0);
      op("top word", 1, 0, 0, 16'h01FE, 16'h0000, 16'hA5C3,
         2, 0, 16'hBE12, 0, 1, 16'h00FF, 16'hA5C3, 0);
      op("top bld", 0, 1, 1, 16'h01FF, 16'h0000, 16'h0000,
         3, 0, 16'hFFA5, 1, 0, 16'h0, 16'h0, 0);
      op("wrap wst", 1, 0, 0, 16'hFFF0, 16'h0012, 16'h1234,
         2, 0, 16'hFFA5, 0, 1, 16'h0001, 16'h1234, 0);
      op("wrap bld hi", 0, 1, 0, 16'hFFFF, 16'h0004, 16'h0000,
         3, 0, 16'h0012, 1, 0, 16'h0, 16'h0, 0);
      op("bst hi", 1, 1, 0, 16'h0003, 16'h0000, 16'hFF9A,
         4, 0, 16'h0012, 1, 1, 16'h0001, 16'h9A34, 0);
      op("bld lo", 0, 1, 1, 16'h0002, 16'h0000, 16'h0000,
         3, 0, 16'h0034, 1, 0, 16'h0, 16'h0, 0);

      w0 = wr_cnt;
      @(negedge clk);
      start = 1'b1; is_store = 1'b1; is_byte = 1'b1; sign_ext = 1'b0;
      base = 16'h0014; offset = 16'h0000; wdata = 16'h0055;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("mid busy", 32'(busy), 1);
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("abort busy", 32'(busy), 0);
      chk("abort done", 32'(done), 0);
      chk("abort fault", 32'(fault), 0);
      chk("abort strobes", 32'({mem_read, mem_write}), 0);
      chk("abort addr", 32'(mem_addr), 0);
      chk("abort wd", 32'(mem_wd), 0);
      chk("abort ld", 32'(load_data), 0);
      rst_n = 1'b1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort no write", wr_cnt - w0, 0);
      chk("abort idle", 32'(busy), 0);
      op("post abort", 0, 0, 0, 16'h0014, 16'h0000, 16'h0000,
         3, 0, 16'hBE12, 1, 0, 16'h0, 16'h0, 0);
      chk("no dual strobe", both_cnt, 0);
      chk("sb empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter: MEM_WORDS, default 256, the number of 16-bit words in the attached data memory.
REQ-002 clk  input  1  single clock; all state changes occur on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on posedge clk.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load; latched with start.
REQ-006 is_byte  input  1  1 = byte access, 0 = word access; latched with start.
REQ-007 sign_ext  input  1  byte loads: 1 = sign-extend, 0 = zero-extend; latched with start.
REQ-008 base  input  16  base byte address; latched with start.
REQ-009 offset  input  16  byte offset; latched with start.
REQ-010 wdata  input  16  store data (byte stores use wdata[7:0]); latched with start.
REQ-011 mem_read  output  1  read strobe to the data memory.
REQ-012 mem_write  output  1  write strobe to the data memory.
REQ-013 mem_addr  output  16  word address to the data memory.
REQ-014 mem_wd  output  16  write data to the data memory.
REQ-015 mem_rd  input  16  registered read data, valid the cycle after mem_read is sampled.
REQ-016 load_data  output  16  memory data register holding the result of the last completed load.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 fault  output  1  valid while done=1: the access was out of range.

Function
REQ-020 eff = (base + offset) mod 2^16 SHALL be computed when start is accepted; word index = eff[15:1]; byte lane = eff[0] (0 = bits [7:0], 1 = bits [15:8]).
REQ-021 The state machine SHALL have these states: IDLE, READ, CAPT, WRITE, DONE.
REQ-022 IDLE with start=1: eff, controls and wdata SHALL be latched; if word index >= MEM_WORDS go to DONE with fault=1; else word load, byte load and byte store go to READ, and word store goes to WRITE.
REQ-023 READ: mem_read=1 for exactly one cycle, then go to CAPT.
REQ-024 CAPT, load: load_data <= mem_rd for a word, or the selected byte sign- or zero-extended for a byte; then go to DONE.
REQ-025 CAPT, byte store: the merge word <= mem_rd with the selected lane replaced by wdata[7:0]; then go to WRITE.
REQ-026 WRITE: mem_write=1 for exactly one cycle with mem_wd = wdata (word) or the merge word (byte); then go to DONE.
REQ-027 DONE: done=1 for one cycle, then go to IDLE; fault=0 unless set by REQ-022.
REQ-028 mem_addr SHALL equal the latched word index whenever mem_read or mem_write is 1; mem_read and mem_write SHALL never both be 1.
REQ-029 start SHALL be ignored while busy=1; a start in the DONE cycle is dropped.
REQ-030 Latency from the start-accepting edge to the done=1 cycle SHALL be: word load 3, byte load 3, word store 2, byte store 4, fault 1.
REQ-031 load_data SHALL change only in CAPT of a load; stores and faults SHALL leave it unchanged.
REQ-032 A faulting access SHALL assert neither mem_read nor mem_write.

Reset
REQ-033 rst_n=0 at posedge clk SHALL force IDLE with busy, done, fault, mem_read, mem_write, mem_addr, mem_wd and load_data all 0, aborting any operation including one mid-byte-store, with no mem_write issued afterwards.

Verification
REQ-034 Word store base=0x0010, offset=0x0004, wdata=0xBEEF -> one mem_write, mem_addr=0x000A, mem_wd=0xBEEF, done 2 cycles after start.
REQ-035 Then word load at the same address -> load_data=0xBEEF, done 3 cycles after start, fault=0.
REQ-036 Byte load eff=0x0015: sign_ext=1 -> load_data=0xFFBE; sign_ext=0 -> 0x00BE.
REQ-037 Byte store wdata=0x0012 to eff=0x0014 -> mem_read then mem_write, mem_wd=0xBE12, done 4 cycles after start; a subsequent word load returns 0xBE12.
REQ-038 Load base=0x0100, offset=0x0100 (eff=0x0200, word index 0x100) -> done with fault=1 1 cycle after start, no mem strobes, load_data unchanged.
REQ-039 Assert rst_n=0 during CAPT of a byte store -> next cycle all outputs 0, no mem_write; a start pulse while busy is ignored.
